// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding single bytes from four requesters into one UART transmitter.
// Each grant issues a tx_start pulse, then tracks tx_busy through the frame before re-arbitrating.
module uart_tx_arb #(
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [1:0]  owner,
    output logic        arb_busy,
    output logic        err,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    localparam int unsigned CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_sat;

    logic             found;
    logic [1:0]       pick;
    logic [1:0]       idx;

    // Search starts at ptr and wraps; the first requesting index wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            owner    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            arb_busy <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    // A busy transmitter here belongs to someone else or is stale; never grant over it.
                    if (found && !tx_busy) begin
                        state    <= WAIT_BUSY;
                        arb_busy <= 1'b1;
                        tx_start <= 1'b1;
                        ack      <= 4'b0001 << pick;
                        owner    <= pick;
                        tx_data  <= req_data[{pick, 3'b000} +: 8];
                        ptr      <= pick + 2'd1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt_sat;
                    if (!tx_busy) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a scoreboard of expected grants is filled as requests are
// driven and drained whenever the arbiter pulses tx_start; a small transmitter model drives tx_busy.
module tb_uart_tx_arb;

    localparam int FRAME = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        arb_busy;
    logic        err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    // 0: normal transmitter, 1: tx_busy tied low, 2: tx_busy tied high
    int   bmode = 0;
    int   bc    = 0;
    logic drop_on_ack = 1'b0;

    uart_tx_arb #(.BUSY_TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .owner    (owner),
        .arb_busy (arb_busy),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter: busy rises one cycle after tx_start is sampled, stays high FRAME cycles.
    always @(posedge clk) begin
        if (rst)            bc <= 0;
        else if (tx_start)  bc <= FRAME + 1;
        else if (bc != 0)   bc <= bc - 1;
    end

    assign tx_busy = (bmode == 2) ? 1'b1 :
                     (bmode == 1) ? 1'b0 : (bc != 0 && bc <= FRAME);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (tx_start) begin
            if (sb.size() == 0) begin
                check("unexpected_start", 32'(tx_start), 32'd0);
            end else begin
                e = sb.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("owner", 32'(owner), 32'(e.who));
                check("ack_grant", 32'(ack), 32'(4'b0001 << e.who));
                check("arb_busy_grant", 32'(arb_busy), 32'd1);
            end
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
        end
        if (drop_on_ack) req = req & ~ack;
    endtask

    task automatic wait_grants(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("all_granted", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((arb_busy || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check("idle", 32'(arb_busy), 32'd0);
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic check_reset_values();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values();

        // Single requester
        drop_on_ack = 1'b1;
        set_byte(0, 8'hA5);
        sb.push_back('{2'd0, 8'hA5});
        req = 4'b0001;
        wait_grants(10);
        wait_idle(30);

        // Simultaneous 1 and 3 from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_byte(1, 8'hB1);
        set_byte(3, 8'hB3);
        sb.push_back('{2'd1, 8'hB1});
        sb.push_back('{2'd3, 8'hB3});
        req = 4'b1010;
        wait_grants(40);
        wait_idle(30);

        // All four held high; ptr must be back at 0
        drop_on_ack = 1'b0;
        req_data = 32'h4332_2110;
        sb.push_back('{2'd0, 8'h10});
        sb.push_back('{2'd1, 8'h21});
        sb.push_back('{2'd2, 8'h32});
        sb.push_back('{2'd3, 8'h43});
        sb.push_back('{2'd0, 8'h10});
        req = 4'b1111;
        wait_grants(100);
        req = '0;
        wait_idle(30);

        // req_data changes right after the grant
        drop_on_ack = 1'b1;
        set_byte(1, 8'h5C);
        sb.push_back('{2'd1, 8'h5C});
        req = 4'b0010;
        wait_grants(10);
        set_byte(1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tx_data_hold", 32'(tx_data), 32'h5C);
        end
        wait_idle(30);
        check("tx_data_hold_idle", 32'(tx_data), 32'h5C);

        // Busy never rises: timeout, then same requester re-granted
        bmode = 1;
        drop_on_ack = 1'b0;
        set_byte(2, 8'h77);
        sb.push_back('{2'd2, 8'h77});
        req = 4'b0100;
        wait_grants(10);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("err_timing", 32'(err), 32'(i == 4));
        end
        check("idle_after_timeout", 32'(arb_busy), 32'd0);
        sb.push_back('{2'd2, 8'h77});
        tick();
        check("regrant_after_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        req = '0;
        wait_idle(20);
        bmode = 0;
        wait_idle(30);

        // Reset while in WAIT_DONE, then tx_busy held high blocks grants
        drop_on_ack = 1'b1;
        set_byte(0, 8'h3C);
        sb.push_back('{2'd0, 8'h3C});
        req = 4'b0001;
        wait_grants(10);
        for (int n = 0; n < 10 && !tx_busy; n++) tick();
        tick();
        check("in_wait_done", 32'(arb_busy), 32'd1);
        bmode = 2;
        set_byte(0, 8'h0A);
        set_byte(1, 8'h1B);
        req = 4'b0011;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_grant_while_busy", 32'(arb_busy), 32'd0);
        end
        sb.push_back('{2'd0, 8'h0A});
        sb.push_back('{2'd1, 8'h1B});
        bmode = 0;
        wait_grants(40);
        wait_idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
